// File: rtl/jpeg_carry_chain_pipe.sv
// jpeg_carry_chain_pipe: segmented add/sub/compare carry chain.
// One SEG-bit segment is resolved per stage, valid/ready on both ends.
module jpeg_carry_chain_pipe #(
  parameter int WIDTH  = 20,
  parameter int SEG    = 5,
  parameter int STAGES = (WIDTH + SEG - 1) / SEG,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic            in_cin,
  input  logic [1:0]      in_mode,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic            out_cout,
  output logic            out_eq,
  output logic            out_lt,
  output logic            out_par,
  output logic [TAGW-1:0] out_tag
);

  localparam int IW = $clog2(WIDTH);

  typedef struct packed {
    logic            v;
    logic [1:0]      mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic            c;
    logic            eq;
    logic            req;
    logic [TAGW-1:0] tag;
  } stage_t;

  stage_t st  [STAGES];
  stage_t nxt [STAGES];
  stage_t src;
  stage_t cur;
  logic [STAGES:0] adv;
  logic cy;
  logic pe;
  logic pr;
  int   bi;

  // scmp flips both MSBs so the unsigned chain gives an offset-binary compare
  always_comb begin : prep
    src      = '0;
    src.v    = in_valid;
    src.mode = in_mode;
    src.a    = in_a;
    src.b    = in_b;
    src.c    = in_cin;
    src.eq   = 1'b1;
    src.req  = (in_a == in_b);
    src.tag  = in_tag;
    if (in_mode != 2'b00) begin
      src.b = ~in_b;
      src.c = 1'b1;
    end
    if (in_mode == 2'b11) begin
      src.a[WIDTH-1] = ~src.a[WIDTH-1];
      src.b[WIDTH-1] = ~src.b[WIDTH-1];
    end
  end

  always_comb begin : chain
    cur = src;
    cy  = 1'b0;
    pe  = 1'b0;
    pr  = 1'b0;
    bi  = 0;
    for (int k = 0; k < STAGES; k++) begin
      nxt[k] = cur;
      cy     = cur.c;
      pe     = cur.eq;
      for (int j = 0; j < SEG; j++) begin
        bi = k * SEG + j;
        if (bi < WIDTH) begin
          pr = cur.a[IW'(bi)] ^ cur.b[IW'(bi)];
          nxt[k].s[IW'(bi)] = pr ^ cy;
          cy = (cur.a[IW'(bi)] & cur.b[IW'(bi)]) | (pr & cy);
          pe = pe & pr;
        end
      end
      nxt[k].c  = cy;
      nxt[k].eq = pe;
      cur = st[k];
    end
  end

  always_comb begin : flow
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      adv[k] = !st[k].v || adv[k+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++)
        st[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          if (nxt[k].v) st[k] <= nxt[k];
          else          st[k].v <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = st[STAGES-1].v;
  assign out_res   = st[STAGES-1].mode[1] ? '0 : st[STAGES-1].s;
  assign out_cout  = st[STAGES-1].c;
  assign out_eq    = (st[STAGES-1].mode == 2'b00) ?
                     st[STAGES-1].req : st[STAGES-1].eq;
  assign out_lt    = (st[STAGES-1].mode != 2'b00) && !st[STAGES-1].c;
  assign out_par   = ^out_res ^ out_cout;
  assign out_tag   = st[STAGES-1].tag;

endmodule

// File: tb/tb_jpeg_carry_chain_pipe.sv
// tb_jpeg_carry_chain_pipe: randomized scoreboard bench for
// jpeg_carry_chain_pipe, default (4-stage) and SEG=7 (3-stage) builds.
module tb_jpeg_carry_chain_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic [19:0] ia, ib;
  logic icin;
  logic [1:0] imode;
  logic [3:0] itag;
  logic vld [2];
  logic rdy_in [2];
  logic ovld [2];
  logic ordy [2];
  logic [19:0] ores [2];
  logic ocout [2], oeq [2], olt [2], opar [2];
  logic [3:0] otag [2];
  logic [31:0] obs [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit lat_chk = 1'b1;
  bit done    = 1'b0;
  logic [31:0] q  [2][$];
  int          cq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jpeg_carry_chain_pipe u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vld[0]), .in_ready(rdy_in[0]),
    .in_a(ia), .in_b(ib), .in_cin(icin),
    .in_mode(imode), .in_tag(itag),
    .out_valid(ovld[0]), .out_ready(ordy[0]),
    .out_res(ores[0]), .out_cout(ocout[0]),
    .out_eq(oeq[0]), .out_lt(olt[0]),
    .out_par(opar[0]), .out_tag(otag[0])
  );

  jpeg_carry_chain_pipe #(.WIDTH(20), .SEG(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vld[1]), .in_ready(rdy_in[1]),
    .in_a(ia), .in_b(ib), .in_cin(icin),
    .in_mode(imode), .in_tag(itag),
    .out_valid(ovld[1]), .out_ready(ordy[1]),
    .out_res(ores[1]), .out_cout(ocout[1]),
    .out_eq(oeq[1]), .out_lt(olt[1]),
    .out_par(opar[1]), .out_tag(otag[1])
  );

  assign obs[0] = {4'b0, otag[0], opar[0], olt[0],
                   oeq[0], ocout[0], ores[0]};
  assign obs[1] = {4'b0, otag[1], opar[1], olt[1],
                   oeq[1], ocout[1], ores[1]};

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Arithmetic reference: plain integer add/sub/compare.
  function automatic logic [31:0] model(logic [19:0] a, logic [19:0] b,
                                        logic cin, logic [1:0] m,
                                        logic [3:0] t);
    logic [20:0] full;
    logic [19:0] r;
    logic co, eq, lt;
    eq = (a == b);
    case (m)
      2'd0: begin
        full = {1'b0, a} + {1'b0, b} + 21'(cin);
        r = full[19:0]; co = full[20]; lt = 1'b0;
      end
      2'd1: begin
        r = a - b; lt = (a < b); co = !lt;
      end
      2'd2: begin
        r = '0; lt = (a < b); co = !lt;
      end
      default: begin
        r = '0; lt = ($signed(a) < $signed(b)); co = !lt;
      end
    endcase
    return 32'({t, ^r ^ co, lt, eq, co, r});
  endfunction

  function automatic logic [19:0] rnd();
    case ($urandom_range(0, 5))
      0: return 20'h00000;
      1: return 20'hFFFFF;
      2: return 20'h80000;
      3: return 20'h7FFFF;
      default: return 20'($urandom);
    endcase
  endfunction

  task automatic send(int g, logic [19:0] a, logic [19:0] b,
                      logic cin, logic [1:0] m, logic [3:0] t);
    bit acc = 1'b0;
    int c = 0;
    ia = a; ib = b; icin = cin; imode = m; itag = t;
    vld[g] = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      #1;
      acc = rdy_in[g];
      c = cyc;
      @(posedge clk);
      if (acc) begin
        q[g].push_back(model(a, b, cin, m, t));
        cq[g].push_back(c + 1);
      end
      @(negedge clk);
    end
    vld[g] = 1'b0;
    if (!acc) check("accept_timeout", 32'(rdy_in[g]), 1);
  endtask

  task automatic drain(int g);
    for (int i = 0; i < 100 && q[g].size() != 0; i++)
      @(negedge clk);
    check("drain", q[g].size(), 0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    logic stall = 1'b0;
    logic [31:0] snap = '0;
    logic [31:0] e;
    int c;
    always begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(ovld[g]), 1);
          check("hold_data", obs[g], snap);
        end
        if (ovld[g] && ordy[g]) begin
          if (q[g].size() == 0) begin
            check("extra_beat", 32'(ovld[g]), 0);
          end else begin
            e = q[g].pop_front();
            c = cq[g].pop_front();
            check("result", obs[g], e);
            if (lat_chk) check("latency", cyc - c + 1, (g == 0) ? 4 : 3);
          end
        end
        stall = ovld[g] && !ordy[g];
        snap  = obs[g];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [19:0] a, b;
    rst_n = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    ia = '0; ib = '0; icin = 1'b0; imode = '0; itag = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3;
    check("rst_valid", 32'(ovld[0]), 0);
    check("rst_outs", obs[0], 0);
    check("rst_ready", 32'(rdy_in[0]), 1);
    check("rst_outs1", obs[1], 0);
    @(negedge clk);

    send(0, 20'hFFFFF, 20'h00001, 1'b0, 2'd0, 4'd1);
    drain(0);
    send(0, 20'h00005, 20'h00007, 1'b0, 2'd1, 4'd2);
    send(0, 20'h12345, 20'h12345, 1'b0, 2'd1, 4'd3);
    send(0, 20'h80000, 20'h00001, 1'b0, 2'd3, 4'd4);
    send(0, 20'h80000, 20'h00001, 1'b0, 2'd2, 4'd5);
    send(0, 20'h00009, 20'h00009, 1'b1, 2'd0, 4'd6);
    drain(0);

    lat_chk = 1'b0;
    ordy[0] = 1'b0;
    c0 = cyc;
    for (int t = 0; t < 4; t++)
      send(0, rnd(), rnd(), 1'($urandom), 2'($urandom), 4'(t));
    check("fill_rate", cyc - c0, 4);
    repeat (6) begin
      #1 check("in_ready_full", 32'(rdy_in[0]), 0);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    for (int t = 4; t < 8; t++)
      send(0, rnd(), rnd(), 1'($urandom), 2'($urandom), 4'(t));
    drain(0);

    lat_chk = 1'b1;
    for (int t = 0; t < 3; t++)
      send(0, rnd(), rnd(), 1'($urandom), 2'($urandom), 4'(9 + t));
    #2;
    rst_n = 1'b0;
    q[0].delete();
    cq[0].delete();
    #1;
    check("async_valid", 32'(ovld[0]), 0);
    check("async_outs", obs[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      #3 check("no_stale", 32'(ovld[0]), 0);
      @(negedge clk);
    end

    lat_chk = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          a = rnd();
          b = ($urandom_range(0, 7) == 0) ? a : rnd();
          send(0, a, b, 1'($urandom), 2'($urandom), 4'($urandom));
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          ordy[0] = ($urandom_range(0, 3) != 0);
        end
        ordy[0] = 1'b1;
      end
    join
    drain(0);

    lat_chk = 1'b1;
    ordy[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = rnd();
      b = ($urandom_range(0, 7) == 0) ? a : rnd();
      send(1, a, b, 1'($urandom), 2'($urandom_range(0, 1)), 4'(i));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    drain(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
